// File: rtl/lmem_port_arbiter_pkg.sv
// Shared helpers for the TyTra LMEM port controllers: index-width sizing and
// one-hot to binary conversion.
package lmem_port_arbiter_pkg;

   localparam int MAX_REQ = 32;

   // Index width for N requesters; one bit minimum so N=1 still has a legal vector.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/lmem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr upward,
// ptr moves past the winner whenever a grant is taken.
module rr_arbiter
   import lmem_port_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req,
   input  logic                advance,
   output logic [N-1:0]        gnt,
   output logic [idx_w(N)-1:0] gnt_idx
);

   localparam int IDX_W = idx_w(N);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Walk ptr, ptr+1, ... modulo N; the first asserted request wins.
   always_comb begin
      gnt  = '0;
      sum  = '0;
      cand = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
         cand = sum[IDX_W-1:0];
         if (gnt == '0 && req[cand]) gnt[cand] = 1'b1;
      end
   end

   assign gnt_idx = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && (|gnt)) begin
         ptr <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/lmem_port_arbiter.sv
// Shares the 1R/1W ports of one LMEM among N_RD readers and N_WR writers,
// each port with its own round-robin arbiter; read data returns one cycle later.
module lmem_port_arbiter
   import lmem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int N_RD       = 4,
   parameter int N_WR       = 2,
   parameter int BYPASS     = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_RD-1:0]            rd_req,
   input  logic [N_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [N_RD-1:0]            rd_gnt,
   output logic [N_RD-1:0]            rd_vld,
   output logic [DATA_WIDTH-1:0]      rd_data,
   input  logic [N_WR-1:0]            wr_req,
   input  logic [N_WR*ADDR_WIDTH-1:0] wr_addr,
   input  logic [N_WR*DATA_WIDTH-1:0] wr_data,
   output logic [N_WR-1:0]            wr_gnt,
   output logic [ADDR_WIDTH-1:0]      mem_raddr,
   input  logic [DATA_WIDTH-1:0]      mem_q,
   output logic                       mem_we,
   output logic [ADDR_WIDTH-1:0]      mem_waddr,
   output logic [DATA_WIDTH-1:0]      mem_wdata
);

   localparam int RD_IDX_W = idx_w(N_RD);
   localparam int WR_IDX_W = idx_w(N_WR);

   logic [N_RD-1:0]       rd_arb_gnt;
   logic [RD_IDX_W-1:0]   rd_idx;
   logic [N_WR-1:0]       wr_arb_gnt;
   logic [WR_IDX_W-1:0]   wr_idx;
   logic                  rd_fire;
   logic                  wr_fire;
   logic [ADDR_WIDTH-1:0] rd_sel_addr;
   logic [ADDR_WIDTH-1:0] last_raddr;

   rr_arbiter #(.N(N_RD)) u_rd_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (rd_req),
      .advance (~rst),
      .gnt     (rd_arb_gnt),
      .gnt_idx (rd_idx)
   );

   rr_arbiter #(.N(N_WR)) u_wr_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (wr_req),
      .advance (~rst),
      .gnt     (wr_arb_gnt),
      .gnt_idx (wr_idx)
   );

   // Grants are gated so nothing reaches the LMEM while reset is asserted.
   assign rd_gnt  = rst ? '0 : rd_arb_gnt;
   assign wr_gnt  = rst ? '0 : wr_arb_gnt;
   assign rd_fire = |rd_gnt;
   assign wr_fire = |wr_gnt;

   assign rd_sel_addr = rd_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign mem_raddr   = rd_fire ? rd_sel_addr : last_raddr;

   assign mem_we    = wr_fire;
   assign mem_waddr = wr_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign mem_wdata = wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld     <= '0;
         last_raddr <= '0;
      end else begin
         rd_vld <= rd_gnt;
         if (rd_fire) last_raddr <= rd_sel_addr;
      end
   end

   generate
      if (BYPASS != 0) begin : g_bypass
         logic                  byp_sel;
         logic [DATA_WIDTH-1:0] byp_data;

         // A same-cycle write to the address being read wins over the stale LMEM output.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               byp_sel  <= 1'b0;
               byp_data <= '0;
            end else begin
               byp_sel  <= rd_fire && wr_fire && (rd_sel_addr == mem_waddr);
               byp_data <= mem_wdata;
            end
         end

         assign rd_data = byp_sel ? byp_data : mem_q;
      end else begin : g_no_bypass
         assign rd_data = mem_q;
      end
   endgenerate

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// Bench for lmem_port_arbiter: LMEM model behind the ports, plus a reference
// model of round-robin order and memory contents driven by random traffic.
module tb_lmem_port_arbiter;

   localparam int DW  = 8;
   localparam int AW  = 6;
   localparam int NR  = 4;
   localparam int NW  = 2;
   localparam int BYP = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    rd_req;
   logic [NR*AW-1:0] rd_addr;
   logic [NR-1:0]    rd_gnt;
   logic [NR-1:0]    rd_vld;
   logic [DW-1:0]    rd_data;
   logic [NW-1:0]    wr_req;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NW-1:0]    wr_gnt;
   logic [AW-1:0]    mem_raddr;
   logic [DW-1:0]    mem_q;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [DW-1:0]    mem_wdata;

   lmem_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_RD(NR), .N_WR(NW), .BYPASS(BYP)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .mem_raddr(mem_raddr), .mem_q(mem_q), .mem_we(mem_we),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
   );

   // LMEM: registered read (old data on same-edge write), synchronous write.
   logic [DW-1:0] lmem [2**AW];
   always @(posedge clk) begin
      if (mem_we) lmem[mem_waddr] <= mem_wdata;
      mem_q <= lmem[mem_raddr];
   end

   // Reference model state
   logic [DW-1:0] shadow [2**AW];
   int            rp, wp;
   logic [AW-1:0] m_last;

   logic [NR-1:0] exp_rg, obs_rg, exp_vld, obs_vld;
   logic [NW-1:0] exp_wg, obs_wg;
   logic [AW-1:0] exp_raddr, obs_raddr, exp_waddr, obs_waddr;
   logic [DW-1:0] exp_wdata, obs_wdata, exp_data, obs_data;
   logic          exp_we, obs_we;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic reset_model();
      rp = 0;
      wp = 0;
      m_last = '0;
   endtask

   // Drives one clock cycle, records DUT observations and model expectations.
   task automatic cycle(input logic [NR-1:0] rq, input logic [NR*AW-1:0] ra,
                        input logic [NW-1:0] wq, input logic [NW*AW-1:0] wa,
                        input logic [NW*DW-1:0] wd);
      int rk, wk;
      logic [AW-1:0] ra_k, wa_k;
      logic [DW-1:0] wd_k;
      rd_req = rq; rd_addr = ra; wr_req = wq; wr_addr = wa; wr_data = wd;
      #1;
      rk = -1;
      wk = -1;
      for (int i = 0; i < NR; i++) begin
         int k;
         k = (rp + i) % NR;
         if (rk < 0 && rq[k]) rk = k;
      end
      for (int i = 0; i < NW; i++) begin
         int k;
         k = (wp + i) % NW;
         if (wk < 0 && wq[k]) wk = k;
      end
      exp_rg = '0;
      exp_wg = '0;
      ra_k = m_last;
      wa_k = '0;
      wd_k = '0;
      if (rk >= 0) begin
         exp_rg[rk] = 1'b1;
         ra_k = ra[rk*AW +: AW];
      end
      if (wk >= 0) begin
         exp_wg[wk] = 1'b1;
         wa_k = wa[wk*AW +: AW];
         wd_k = wd[wk*DW +: DW];
      end
      exp_raddr = ra_k;
      exp_we    = (wk >= 0);
      exp_waddr = wa_k;
      exp_wdata = wd_k;
      obs_rg = rd_gnt; obs_wg = wr_gnt; obs_raddr = mem_raddr;
      obs_we = mem_we; obs_waddr = mem_waddr; obs_wdata = mem_wdata;
      exp_vld = exp_rg;
      if (rk >= 0)
         exp_data = (BYP != 0 && wk >= 0 && wa_k == ra_k) ? wd_k : shadow[ra_k];
      if (wk >= 0) begin
         shadow[wa_k] = wd_k;
         wp = (wk + 1) % NW;
      end
      if (rk >= 0) begin
         rp = (rk + 1) % NR;
         m_last = ra_k;
      end
      @(posedge clk);
      #1;
      obs_vld  = rd_vld;
      obs_data = rd_data;
   endtask

   task automatic test_reset();
      rd_req = '1; rd_addr = '0; wr_req = '1; wr_addr = '0; wr_data = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({rd_gnt, wr_gnt, mem_we, rd_vld} !== '0)
         $display("FAIL reset_outputs: got gnt=%b/%b we=%b vld=%b, want all zero",
                  rd_gnt, wr_gnt, mem_we, rd_vld);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      for (int c = 0; c < 10; c++) begin
         cycle('0, '0, '0, '0, '0);
         n_checks++;
         if ({obs_rg, obs_wg, obs_we, obs_vld, obs_raddr} !== '0)
            $display("FAIL idle_c%0d: got rg=%b wg=%b we=%b vld=%b raddr=%0d, want zeros",
                     c, obs_rg, obs_wg, obs_we, obs_vld, obs_raddr);
         else n_pass++;
      end
   endtask

   task automatic test_preload();
      for (int a = 0; a < 2**AW; a++) begin
         cycle('0, '0, 2'b01, {6'd0, 6'(a)}, {8'd0, 8'($urandom)});
         n_checks++;
         if (obs_wg !== 2'b01 || obs_we !== 1'b1 || obs_waddr !== exp_waddr || obs_wdata !== exp_wdata)
            $display("FAIL preload_a%0d: got wg=%b we=%b %0d<=%h, want 01 1 %0d<=%h",
                     a, obs_wg, obs_we, obs_waddr, obs_wdata, exp_waddr, exp_wdata);
         else n_pass++;
      end
   endtask

   task automatic test_read_rr();
      logic [NR*AW-1:0] ra;
      ra = (NR*AW)'($urandom);
      for (int c = 0; c < 8; c++) begin
         cycle(4'b1111, ra, '0, '0, '0);
         n_checks++;
         if (obs_rg !== NR'(1 << (c % NR)) || obs_raddr !== ra[(c % NR)*AW +: AW])
            $display("FAIL read_rr_c%0d: got gnt=%b raddr=%0d, want gnt=%b raddr=%0d",
                     c, obs_rg, obs_raddr, NR'(1 << (c % NR)), ra[(c % NR)*AW +: AW]);
         else n_pass++;
         n_checks++;
         if (obs_vld !== exp_vld || obs_data !== exp_data)
            $display("FAIL read_ret_c%0d: got vld=%b data=%h, want vld=%b data=%h",
                     c, obs_vld, obs_data, exp_vld, exp_data);
         else n_pass++;
      end
   endtask

   task automatic test_write_rr();
      logic [NW-1:0] prev;
      prev = '0;
      for (int c = 0; c < 4; c++) begin
         cycle('0, '0, 2'b11, {6'd7, 6'd3}, {8'h5A, 8'hA5});
         n_checks++;
         if (obs_wg !== exp_wg || obs_we !== 1'b1 || (c > 0 && obs_wg !== ~prev))
            $display("FAIL write_rr_c%0d: got wg=%b we=%b, want wg=%b we=1", c, obs_wg, obs_we, exp_wg);
         else n_pass++;
         prev = obs_wg;
      end
      cycle(4'b0001, {18'd0, 6'd3}, '0, '0, '0);
      n_checks++;
      if (obs_vld !== 4'b0001 || obs_data !== 8'hA5)
         $display("FAIL readback_3: got vld=%b data=%h, want 0001 a5", obs_vld, obs_data);
      else n_pass++;
      cycle(4'b0010, {12'd0, 6'd7, 6'd0}, '0, '0, '0);
      n_checks++;
      if (obs_vld !== 4'b0010 || obs_data !== 8'h5A)
         $display("FAIL readback_7: got vld=%b data=%h, want 0010 5a", obs_vld, obs_data);
      else n_pass++;
   endtask

   task automatic test_collision();
      cycle('0, '0, 2'b01, {6'd0, 6'd5}, {8'd0, 8'h11});
      cycle(4'b0001, {18'd0, 6'd5}, 2'b01, {6'd0, 6'd5}, {8'd0, 8'h3C});
      n_checks++;
      if (obs_vld !== 4'b0001 || obs_data !== ((BYP != 0) ? 8'h3C : 8'h11) || obs_data !== exp_data)
         $display("FAIL collision: got vld=%b data=%h, want 0001 %h", obs_vld, obs_data,
                  (BYP != 0) ? 8'h3C : 8'h11);
      else n_pass++;
      cycle(4'b0001, {18'd0, 6'd5}, '0, '0, '0);
      n_checks++;
      if (obs_data !== 8'h3C)
         $display("FAIL after_collision: got data=%h, want 3c", obs_data);
      else n_pass++;
   endtask

   task automatic test_wrap();
      cycle(4'b0100, {6'd9, 6'd10, 6'd11, 6'd12}, '0, '0, '0);
      cycle(4'b0100, {6'd9, 6'd10, 6'd11, 6'd12}, '0, '0, '0);
      n_checks++;
      if (obs_rg !== 4'b0100 || obs_raddr !== 6'd10)
         $display("FAIL wrap_gnt: got gnt=%b raddr=%0d, want 0100 10", obs_rg, obs_raddr);
      else n_pass++;
      cycle(4'b1111, {6'd9, 6'd10, 6'd11, 6'd12}, '0, '0, '0);
      n_checks++;
      if (obs_rg !== 4'b1000 || obs_data !== exp_data)
         $display("FAIL wrap_ptr3: got gnt=%b data=%h, want 1000 %h", obs_rg, obs_data, exp_data);
      else n_pass++;
   endtask

   task automatic test_reset_inflight();
      cycle(4'b0100, {6'd1, 6'd2, 6'd3, 6'd4}, '0, '0, '0);
      rst = 1'b1;
      #1;
      n_checks++;
      if (rd_vld !== '0 || rd_gnt !== '0)
         $display("FAIL inflight_rst: got vld=%b gnt=%b, want 0000 0000", rd_vld, rd_gnt);
      else n_pass++;
      rd_req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      @(posedge clk);
      #1;
      n_checks++;
      if (rd_vld !== '0 || mem_raddr !== '0)
         $display("FAIL post_rst_idle: got vld=%b raddr=%0d, want 0000 0", rd_vld, mem_raddr);
      else n_pass++;
      cycle(4'b1010, {6'd20, 6'd21, 6'd22, 6'd23}, '0, '0, '0);
      n_checks++;
      if (obs_rg !== 4'b0010 || obs_vld !== 4'b0010 || obs_data !== exp_data)
         $display("FAIL post_rst_gnt: got gnt=%b vld=%b data=%h, want 0010 0010 %h",
                  obs_rg, obs_vld, obs_data, exp_data);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [NR-1:0]    rpend;
      logic [NR*AW-1:0] ra;
      logic [NW-1:0]    wpend;
      logic [NW*AW-1:0] wa;
      logic [NW*DW-1:0] wd;
      rpend = '0; ra = '0; wpend = '0; wa = '0; wd = '0;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!rpend[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  rpend[i] = 1'b1;
                  ra[i*AW +: AW] = AW'($urandom_range(0, 7));
               end
            end else if ($urandom_range(0, 9) == 0) begin
               rpend[i] = 1'b0;
            end
         end
         for (int i = 0; i < NW; i++) begin
            if (!wpend[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  wpend[i] = 1'b1;
                  wa[i*AW +: AW] = AW'($urandom_range(0, 7));
                  wd[i*DW +: DW] = DW'($urandom);
               end
            end else if ($urandom_range(0, 9) == 0) begin
               wpend[i] = 1'b0;
            end
         end
         cycle(rpend, ra, wpend, wa, wd);
         rpend = rpend & ~exp_rg;
         wpend = wpend & ~exp_wg;
         n_checks++;
         if (obs_rg !== exp_rg || obs_wg !== exp_wg)
            $display("FAIL rand_gnt_c%0d: got rg=%b wg=%b, want rg=%b wg=%b",
                     c, obs_rg, obs_wg, exp_rg, exp_wg);
         else n_pass++;
         n_checks++;
         if (obs_raddr !== exp_raddr)
            $display("FAIL rand_raddr_c%0d: got %0d, want %0d", c, obs_raddr, exp_raddr);
         else n_pass++;
         n_checks++;
         if (obs_we !== exp_we || (exp_we && {obs_waddr, obs_wdata} !== {exp_waddr, exp_wdata}))
            $display("FAIL rand_wr_c%0d: got we=%b %0d<=%h, want we=%b %0d<=%h",
                     c, obs_we, obs_waddr, obs_wdata, exp_we, exp_waddr, exp_wdata);
         else n_pass++;
         n_checks++;
         if (obs_vld !== exp_vld || (exp_vld != '0 && obs_data !== exp_data))
            $display("FAIL rand_ret_c%0d: got vld=%b data=%h, want vld=%b data=%h",
                     c, obs_vld, obs_data, exp_vld, exp_data);
         else n_pass++;
      end
   endtask

   initial begin
      reset_model();
      test_reset();
      test_preload();
      test_read_rr();
      test_write_rr();
      test_collision();
      test_wrap();
      test_reset_inflight();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
